// File: rtl/cfi_shadow_stack_stage.sv
// cfi_shadow_stack_stage
//   Buffers committed CFI events (CALL / RET / CORET) from NR_COMMIT_PORTS
//   commit ports in a small FIFO, drains one per cycle into a circular
//   hardware shadow stack and checks backward-edge targets.
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   en_i                    gates new enqueues only
//   flush_i                 clears FIFO/stack/lost and returns to RUN
//   ev_valid_i/kind/link/target  per-port event bundle (flat, port 0 lowest)
//   cfi_wait_o              stall commit when free FIFO slots < ports
//   cfi_fault_*_o           one-cycle registered fault pulse + cause/tval
//   depth_o                 valid shadow stack entries

// Per-port qualifier: does this port want a FIFO slot this cycle?
module cfi_port_decode (
  input  logic       valid,
  input  logic [1:0] kind,
  input  logic       gate,
  output logic       want
);
  assign want = gate & valid & (kind != 2'b00);
endmodule

module cfi_shadow_stack_stage #(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int XLEN            = 64,
  parameter int FIFO_DEPTH      = 4,
  parameter int STACK_DEPTH     = 8,
  parameter int LOST_W          = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic                            flush_i,
  input  logic [NR_COMMIT_PORTS-1:0]      ev_valid_i,
  input  logic [2*NR_COMMIT_PORTS-1:0]    ev_kind_i,
  input  logic [XLEN*NR_COMMIT_PORTS-1:0] ev_link_i,
  input  logic [XLEN*NR_COMMIT_PORTS-1:0] ev_target_i,
  output logic                            cfi_wait_o,
  output logic                            cfi_fault_valid_o,
  output logic [1:0]                      cfi_fault_cause_o,
  output logic [XLEN-1:0]                 cfi_fault_tval_o,
  output logic [$clog2(STACK_DEPTH):0]    depth_o
);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int SAW = $clog2(STACK_DEPTH);

  typedef struct packed {
    logic [1:0]      kind;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] target;
  } cfi_ev_t;

  typedef enum logic {RUN, HALT} state_t;

  cfi_ev_t         fifo_q [FIFO_DEPTH];
  logic [XLEN-1:0] stk_q  [STACK_DEPTH];
  logic [FAW:0]    wp_q, rp_q, count, free;
  logic [SAW-1:0]  top_q;
  logic [SAW:0]    depth_q;
  logic [LOST_W-1:0] lost_q;
  state_t          state_q;

  // Pointers carry a wrap bit so full/empty fall out of the difference.
  assign count      = wp_q - rp_q;
  assign free       = (FAW+1)'(FIFO_DEPTH) - count;
  assign cfi_wait_o = free < (FAW+1)'(NR_COMMIT_PORTS);
  assign depth_o    = depth_q;

  // ---------------- enqueue ----------------
  logic [NR_COMMIT_PORTS-1:0]        want, acc;
  logic [NR_COMMIT_PORTS-1:0][FAW:0] slot;
  logic [FAW:0]                      nacc;
  logic                              ovr;

  for (genvar p = 0; p < NR_COMMIT_PORTS; p++) begin : g_port
    cfi_port_decode u_dec (
      .valid(ev_valid_i[p]),
      .kind (ev_kind_i[2*p +: 2]),
      .gate (en_i & ~flush_i),
      .want (want[p])
    );
  end

  // Slots are handed out in port order; anything past the free count is dropped.
  always_comb begin
    nacc = '0;
    ovr  = 1'b0;
    acc  = '0;
    slot = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      slot[i] = wp_q + nacc;
      if (want[i]) begin
        if (nacc < free) begin
          acc[i] = 1'b1;
          nacc   = nacc + 1'b1;
        end else begin
          ovr = 1'b1;
        end
      end
    end
  end

  // ---------------- drain / check ----------------
  cfi_ev_t         head;
  logic            drain;
  logic [SAW-1:0]  top_m1, t_n, push_idx;
  logic [SAW:0]    d_n;
  logic [LOST_W-1:0] l_n;
  logic            flt, push_en;
  logic [1:0]      flt_cause;
  logic [XLEN-1:0] flt_tval;

  assign head   = fifo_q[rp_q[FAW-1:0]];
  assign drain  = (count != '0) && (state_q == RUN) && !flush_i;
  assign top_m1 = top_q - 1'b1;

  // kind[1] = return check (RET, CORET), kind[0] = push link (CALL, CORET).
  always_comb begin
    d_n       = depth_q;
    t_n       = top_q;
    l_n       = lost_q;
    flt       = 1'b0;
    flt_cause = 2'b00;
    flt_tval  = '0;
    push_en   = 1'b0;
    push_idx  = top_q;
    if (drain) begin
      if (head.kind[1]) begin
        if (depth_q != '0) begin
          d_n = depth_q - 1'b1;
          t_n = top_m1;
          if (stk_q[top_m1] != head.target) begin
            flt       = 1'b1;
            flt_cause = 2'b01;
            flt_tval  = head.target;
          end
        end else if (lost_q != '0) begin
          // Entry was overwritten earlier: cannot check, just account for it.
          l_n = lost_q - 1'b1;
        end else begin
          flt       = 1'b1;
          flt_cause = 2'b10;
          flt_tval  = head.target;
        end
      end
      if (head.kind[0] && !flt) begin
        push_en  = 1'b1;
        push_idx = t_n;
        t_n      = t_n + 1'b1;
        if (d_n == (SAW+1)'(STACK_DEPTH)) begin
          if (l_n != {LOST_W{1'b1}}) l_n = l_n + 1'b1;
        end else begin
          d_n = d_n + 1'b1;
        end
      end
    end
    // Check faults outrank a simultaneous overrun.
    if (!flt && ovr) begin
      flt       = 1'b1;
      flt_cause = 2'b11;
      flt_tval  = '0;
    end
  end

  // ---------------- storage (no reset needed) ----------------
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NR_COMMIT_PORTS; i++)
      if (acc[i])
        fifo_q[slot[i][FAW-1:0]] <= '{kind:   ev_kind_i[2*i +: 2],
                                      link:   ev_link_i[XLEN*i +: XLEN],
                                      target: ev_target_i[XLEN*i +: XLEN]};
    if (push_en) stk_q[push_idx] <= head.link;
  end

  // ---------------- control ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q              <= '0;
      rp_q              <= '0;
      top_q             <= '0;
      depth_q           <= '0;
      lost_q            <= '0;
      state_q           <= RUN;
      cfi_fault_valid_o <= 1'b0;
      cfi_fault_cause_o <= 2'b00;
      cfi_fault_tval_o  <= '0;
    end else if (flush_i) begin
      wp_q              <= '0;
      rp_q              <= '0;
      top_q             <= '0;
      depth_q           <= '0;
      lost_q            <= '0;
      state_q           <= RUN;
      cfi_fault_valid_o <= 1'b0;
      cfi_fault_cause_o <= 2'b00;
      cfi_fault_tval_o  <= '0;
    end else begin
      wp_q              <= wp_q + nacc;
      rp_q              <= rp_q + (FAW+1)'(drain);
      top_q             <= t_n;
      depth_q           <= d_n;
      lost_q            <= l_n;
      if (flt) state_q  <= HALT;
      cfi_fault_valid_o <= flt;
      cfi_fault_cause_o <= flt_cause;
      cfi_fault_tval_o  <= flt_tval;
    end
  end
endmodule

// File: tb/tb_cfi_shadow_stack_stage.sv
module tb_cfi_shadow_stack_stage;
  localparam int N = 2;
  localparam int X = 64;

  logic           clk = 0, rst = 1, en = 1, flush = 0;
  logic [N-1:0]   ev_valid = '0;
  logic [2*N-1:0] ev_kind = '0;
  logic [X*N-1:0] ev_link = '0, ev_target = '0;
  logic           cfi_wait, f_valid;
  logic [1:0]     f_cause;
  logic [X-1:0]   f_tval;
  logic [3:0]     depth;

  cfi_shadow_stack_stage #(.NR_COMMIT_PORTS(N), .XLEN(X), .FIFO_DEPTH(4),
                           .STACK_DEPTH(8), .LOST_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush),
    .ev_valid_i(ev_valid), .ev_kind_i(ev_kind), .ev_link_i(ev_link),
    .ev_target_i(ev_target), .cfi_wait_o(cfi_wait),
    .cfi_fault_valid_o(f_valid), .cfi_fault_cause_o(f_cause),
    .cfi_fault_tval_o(f_tval), .depth_o(depth));

  always #5 clk = ~clk;

  localparam logic [1:0] CALL = 2'b01, RET = 2'b10, CORET = 2'b11;

  typedef struct packed { logic [1:0] cause; logic [X-1:0] tval; } flt_t;
  flt_t exp_q[$];
  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [X-1:0] act, input logic [X-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every fault pulse must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && f_valid) begin
      if (exp_q.size() == 0) chk("unexpected_fault_cause", {62'd0, f_cause}, 64'd0);
      else begin
        flt_t e;
        e = exp_q.pop_front();
        chk("fault_cause", {62'd0, f_cause}, {62'd0, e.cause});
        chk("fault_tval", f_tval, e.tval);
      end
    end
  end

  task automatic clear_in();
    ev_valid = '0; ev_kind = '0; ev_link = '0; ev_target = '0;
  endtask

  task automatic idle(input int n);
    clear_in();
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic ev(input logic [1:0] k, input logic [X-1:0] l, input logic [X-1:0] t);
    clear_in();
    ev_valid[0] = 1'b1; ev_kind[1:0] = k; ev_link[X-1:0] = l; ev_target[X-1:0] = t;
    @(posedge clk); #1;
    clear_in();
  endtask

  task automatic ev2(input logic [1:0] k0, input logic [X-1:0] l0, input logic [X-1:0] t0,
                     input logic [1:0] k1, input logic [X-1:0] l1, input logic [X-1:0] t1);
    ev_valid = 2'b11;
    ev_kind = {k1, k0}; ev_link = {l1, l0}; ev_target = {t1, t0};
    @(posedge clk); #1;
    clear_in();
  endtask

  task automatic do_flush();
    clear_in();
    flush = 1; @(posedge clk); #1; flush = 0;
  endtask

  initial begin
    logic saw_wait;
    logic [X-1:0] links [6];
    int budget;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_depth", {60'd0, depth}, 64'd0);
    chk("reset_wait", {63'd0, cfi_wait}, 64'd0);
    chk("reset_fvalid", {63'd0, f_valid}, 64'd0);
    chk("reset_cause", {62'd0, f_cause}, 64'd0);
    chk("reset_tval", f_tval, 64'd0);
    rst = 0;
    idle(1);

    // 1: matched CALL/RET
    ev(CALL, 64'h1000, 0); idle(3);
    chk("t1_depth_after_call", {60'd0, depth}, 64'd1);
    ev(RET, 0, 64'h1000); idle(3);
    chk("t1_depth_after_ret", {60'd0, depth}, 64'd0);

    // 2: mismatch -> HALT, later events stay buffered
    ev(CALL, 64'h1000, 0);
    exp_q.push_back('{2'b01, 64'h2000});
    ev(RET, 0, 64'h2000); idle(3);
    ev(CALL, 64'h3000, 0); ev(CALL, 64'h3100, 0); ev(CALL, 64'h3200, 0); idle(3);
    chk("t2_halt_depth", {60'd0, depth}, 64'd0);
    chk("t2_halt_wait", {63'd0, cfi_wait}, 64'd1);
    do_flush();
    chk("t2_flush_wait", {63'd0, cfi_wait}, 64'd0);
    ev(CALL, 64'h4000, 0); idle(3);
    chk("t2_run_after_flush", {60'd0, depth}, 64'd1);
    do_flush();

    // 3: overflow of the shadow stack, lost accounting, underflow
    for (int k = 1; k <= 10; k++) ev(CALL, 64'(k * 256), 0);
    idle(3);
    chk("t3_full_depth", {60'd0, depth}, 64'd8);
    for (int k = 10; k >= 1; k--) ev(RET, 0, 64'(k * 256));
    idle(3);
    chk("t3_empty_depth", {60'd0, depth}, 64'd0);
    exp_q.push_back('{2'b10, 64'h55});
    ev(RET, 0, 64'h55); idle(3);
    do_flush();

    // 4: dual-port CALLs honouring cfi_wait
    saw_wait = 0;
    for (int c = 0; c < 3; c++) begin
      budget = 0;
      while (cfi_wait && budget < 20) begin saw_wait = 1; idle(1); budget++; end
      if (budget >= 20) chk("t4_wait_timeout", 64'd1, 64'd0);
      links[2*c]   = 64'h5000 + 64'(c * 16);
      links[2*c+1] = 64'h5008 + 64'(c * 16);
      if (cfi_wait) saw_wait = 1;
      ev2(CALL, links[2*c], 0, CALL, links[2*c+1], 0);
      if (cfi_wait) saw_wait = 1;
    end
    idle(6);
    chk("t4_saw_wait", {63'd0, saw_wait}, 64'd1);
    chk("t4_depth", {60'd0, depth}, 64'd6);
    for (int k = 5; k >= 0; k--) ev(RET, 0, links[k]);
    idle(3);
    chk("t4_depth_after_rets", {60'd0, depth}, 64'd0);
    do_flush();

    // 5: CORET replaces top
    ev(CALL, 64'hA0, 0); idle(2);
    ev(CORET, 64'hB0, 64'hA0); idle(3);
    chk("t5_coret_depth", {60'd0, depth}, 64'd1);
    ev(RET, 0, 64'hB0); idle(3);
    chk("t5_ret_new_top", {60'd0, depth}, 64'd0);

    // en_i=0 gates enqueue
    en = 0; ev(CALL, 64'h77, 0); idle(3); en = 1;
    chk("en_off_depth", {60'd0, depth}, 64'd0);

    // overrun while halted
    ev(CALL, 64'h10, 0);
    exp_q.push_back('{2'b01, 64'h20});
    ev(RET, 0, 64'h20); idle(3);
    ev2(CALL, 1, 0, CALL, 2, 0);
    ev2(CALL, 3, 0, CALL, 4, 0);
    exp_q.push_back('{2'b11, 64'h0});
    ev2(CALL, 5, 0, CALL, 6, 0);
    idle(3);
    do_flush();

    // 6a: flush in the cycle the offending RET would drain
    ev(CALL, 64'h10, 0); idle(2);
    ev(RET, 0, 64'h20);
    flush = 1; @(posedge clk); #1; flush = 0;
    idle(3);
    chk("t6_flush_depth", {60'd0, depth}, 64'd0);
    chk("t6_flush_wait", {63'd0, cfi_wait}, 64'd0);

    // 6b: reset mid-drain
    ev(CALL, 64'h10, 0); idle(2);
    ev(RET, 0, 64'h20);
    rst = 1; #2;
    chk("t6_rst_depth", {60'd0, depth}, 64'd0);
    chk("t6_rst_fvalid", {63'd0, f_valid}, 64'd0);
    idle(2);
    rst = 0;
    idle(3);
    chk("t6_rst_wait", {63'd0, cfi_wait}, 64'd0);
    chk("t6_rst_depth_after", {60'd0, depth}, 64'd0);

    idle(4);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
